io_stim_sequencer: RTL and testbench
====================================

IO_STIM_SEQUENCER -- requirements
Module: io_stim_sequencer

Interface
REQ-001 SHALL have parameter SW_BITS, default 10: width of the switch output vector.
REQ-002 SHALL have parameter KEY_BITS, default 4: width of the key output vector.
REQ-003 SHALL have parameter PERIOD, default 258: clock cycles between steps; legal range is 2 or more.
REQ-004 SHALL have parameter START_DELAY, default 2: hold-off cycles after reset before stepping begins.
REQ-005 SHALL have parameter DEPTH, default 8: number of table entries, a power of 2.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: 1 = run, 0 = pause.
REQ-009 SHALL have port mode, input, 2 bits: 0 TOGGLE, 1 WALK, 2 TABLE, 3 HOLD.
REQ-010 SHALL have port loop, input, 1 bit: in TABLE mode, 1 = wrap the index, 0 = stop at the last entry.
REQ-011 SHALL have table write ports tbl_we (1 bit), tbl_addr (log2(DEPTH) bits) and tbl_data (SW_BITS+KEY_BITS bits; SW field in the upper bits).
REQ-012 SHALL have outputs SW (SW_BITS) and KEY (KEY_BITS): the driven stimulus vectors.
REQ-013 SHALL have output step_strobe, 1 bit: pulses for one cycle when SW/KEY update.
REQ-014 SHALL have output step_count, 16 bits: number of steps taken.
REQ-015 SHALL have output done, 1 bit: high in state DONE.

Function
REQ-016 SHALL implement states HOLDOFF, RUN, PAUSE and DONE.
REQ-017 SHALL, in HOLDOFF, count START_DELAY cycles and then enter RUN, or PAUSE if enable=0.
REQ-018 SHALL, in RUN, advance a period counter through 0..PERIOD-1 and step on the edge where the counter is at PERIOD-1, so the first step lands exactly PERIOD cycles after RUN is entered.
REQ-019 SHALL, in TOGGLE mode, invert SW and KEY bitwise on each step.
REQ-020 SHALL, in WALK mode, rotate SW left by 1 and KEY left by 1 (MSB goes to LSB) on each step.
REQ-021 SHALL, in TABLE mode, load SW/KEY from table[idx] on each step and then increment idx.
REQ-022 SHALL, in TABLE mode, on the step that loads idx=DEPTH-1: wrap idx to 0 if loop=1; otherwise enter DONE with step_strobe still asserted on that step.
REQ-023 SHALL, in HOLD mode, leave SW/KEY unchanged while still pulsing step_strobe and counting steps.
REQ-024 SHALL move from RUN to PAUSE on enable=0, freezing the counter, idx and outputs; enable=1 returns to RUN and the count resumes where it stopped.
REQ-025 SHALL sample mode at the step edge only; a mode change mid-period takes effect at the next step, with no counter restart.
REQ-026 SHALL, when tbl_we targets the entry being read on the same step, output the old data (read-before-write).
REQ-027 SHALL saturate step_count at 16'hFFFF.
REQ-028 SHALL hold DONE until RESET; in DONE, enable and mode are ignored.

Reset
REQ-029 SHALL, on RESET=1 at a clock edge, set SW to all ones, KEY to all ones, step_strobe=0, step_count=0, done=0, idx=0, counters=0 and state HOLDOFF, and do so from any state, including mid-period.
REQ-030 SHALL leave table contents unchanged by RESET.

Structure
REQ-031 SHALL take the mode and state enumerations and the default parameter values from shared package io_stim_pkg.
REQ-032 SHALL implement the period counter as sub-module stim_period_counter (inputs: enable, clear; output: wrap pulse).
REQ-033 SHALL implement the table as a register array with a synchronous write and a combinational read.

Verification
REQ-034 SHALL cover: PERIOD=4, START_DELAY=2, TOGGLE, enable=1 -> SW=10'h3FF until cycle 6 after reset release, then 10'h000 with step_strobe pulsing, and SW=10'h3FF at cycle 10.
REQ-035 SHALL cover: WALK with SW=10'h001 preloaded via one TABLE step -> 10'h002, 10'h004 on the following steps, and 10'h200 wrapping to 10'h001.
REQ-036 SHALL cover: TABLE, DEPTH=8, loop=0, entries 0..7 -> eight strobes, done=1 on the 8th step, and no further change in SW/KEY.
REQ-037 SHALL cover: enable=0 for 5 cycles mid-period (counter at 2 of 4) -> the next step is delayed by exactly 5 cycles.
REQ-038 SHALL cover: RESET asserted for 1 cycle at counter=3 in TABLE mode -> SW=10'h3FF, KEY=4'hF, step_count=0 on the next cycle, and the table retained.
REQ-039 SHALL cover: tbl_we to idx 0 coinciding with a step that reads idx 0 -> the old value is output, and the new value is output on the wrap.

Source files
------------

// File: rtl/io_stim_pkg.sv
// Shared enumerations and default parameter values for the IO stimulus sequencer.
package io_stim_pkg;

    localparam int unsigned SW_BITS_DEF     = 10;
    localparam int unsigned KEY_BITS_DEF    = 4;
    localparam int unsigned PERIOD_DEF      = 258;
    localparam int unsigned START_DELAY_DEF = 2;
    localparam int unsigned DEPTH_DEF       = 8;
    localparam int unsigned STEP_CNT_BITS   = 16;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_TABLE  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/stim_period_counter.sv
// Free-running 0..PERIOD-1 counter; wrap_c marks the cycle whose edge ends a period.
module stim_period_counter #(
    parameter int unsigned PERIOD = io_stim_pkg::PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap_c
);

    localparam int unsigned CW = $clog2(PERIOD);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last_c;

    always_comb begin
        at_last_c = (cnt_q == CW'(PERIOD - 1));
        cnt_d     = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_last_c ? '0 : cnt_q + CW'(1);
        end
    end

    assign wrap_c = enable && !clear && at_last_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_stim_sequencer.sv
// Drives SW/KEY stimulus vectors that step every PERIOD cycles in toggle, walk,
// table-playback or hold mode, with hold-off after reset and pause on enable=0.
module io_stim_sequencer
    import io_stim_pkg::*;
#(
    parameter int unsigned SW_BITS     = SW_BITS_DEF,
    parameter int unsigned KEY_BITS    = KEY_BITS_DEF,
    parameter int unsigned PERIOD      = PERIOD_DEF,
    parameter int unsigned START_DELAY = START_DELAY_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF
) (
    input  logic                              CLOCK_50,
    input  logic                              RESET,
    input  logic                              enable,
    input  logic [1:0]                        mode,
    input  logic                              loop,
    input  logic                              tbl_we,
    input  logic [$clog2(DEPTH)-1:0]          tbl_addr,
    input  logic [SW_BITS+KEY_BITS-1:0]       tbl_data,
    output logic [SW_BITS-1:0]                SW,
    output logic [KEY_BITS-1:0]               KEY,
    output logic                              step_strobe,
    output logic [STEP_CNT_BITS-1:0]          step_count,
    output logic                              done
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned TW        = SW_BITS + KEY_BITS;
    localparam int unsigned HOLD_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;
    localparam int unsigned HW        = (HOLD_LAST < 1) ? 1 : $clog2(HOLD_LAST + 1);

    state_e                     state_q, state_d;
    logic [HW-1:0]              hold_q, hold_d;
    logic [SW_BITS-1:0]         sw_q, sw_d;
    logic [KEY_BITS-1:0]        key_q, key_d;
    logic                       strobe_q, strobe_d;
    logic [STEP_CNT_BITS-1:0]   count_q, count_d;
    logic                       done_q, done_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic [TW-1:0]              tbl_q [DEPTH];

    mode_e                      mode_c;
    logic [TW-1:0]              tbl_rd_c;
    logic                       step_c;
    logic                       cnt_en_c;
    logic                       cnt_clr_c;
    logic                       last_step_c;

    assign mode_c    = mode_e'(mode);
    assign tbl_rd_c  = tbl_q[idx_q];
    assign cnt_en_c  = enable && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
    assign cnt_clr_c = (state_q == ST_HOLDOFF);

    // Counting in PAUSE too makes a pause delay the next step by exactly its length.
    stim_period_counter #(
        .PERIOD (PERIOD)
    ) u_period (
        .clk    (CLOCK_50),
        .rst    (RESET),
        .enable (cnt_en_c),
        .clear  (cnt_clr_c),
        .wrap_c (step_c)
    );

    assign last_step_c = step_c && (mode_c == MODE_TABLE) && !loop
                         && (idx_q == AW'(DEPTH - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_HOLDOFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_HOLDOFF: begin
                if (hold_q == HW'(HOLD_LAST)) begin
                    state_d = enable ? ST_RUN : ST_PAUSE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (last_step_c) begin
                    state_d = ST_DONE;
                end else if (!enable) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (last_step_c) begin
                    state_d = ST_DONE;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_HOLDOFF;
            end
        endcase
    end

    // Mode is only looked at on a step edge, so mid-period changes wait for the next step.
    always_comb begin
        sw_d     = sw_q;
        key_d    = key_q;
        idx_d    = idx_q;
        count_d  = count_q;
        strobe_d = step_c;
        done_d   = (state_d == ST_DONE);
        if (step_c) begin
            if (count_q != {STEP_CNT_BITS{1'b1}}) begin
                count_d = count_q + STEP_CNT_BITS'(1);
            end
            unique case (mode_c)
                MODE_TOGGLE: begin
                    sw_d  = ~sw_q;
                    key_d = ~key_q;
                end
                MODE_WALK: begin
                    sw_d  = (sw_q << 1) | (sw_q >> (SW_BITS - 1));
                    key_d = (key_q << 1) | (key_q >> (KEY_BITS - 1));
                end
                MODE_TABLE: begin
                    sw_d  = tbl_rd_c[TW-1 -: SW_BITS];
                    key_d = tbl_rd_c[KEY_BITS-1:0];
                    idx_d = idx_q + AW'(1);
                end
                MODE_HOLD: begin
                    sw_d  = sw_q;
                    key_d = key_q;
                end
                default: begin
                    sw_d  = sw_q;
                    key_d = key_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hold_q   <= '0;
            sw_q     <= '1;
            key_q    <= '1;
            strobe_q <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            hold_q   <= hold_d;
            sw_q     <= sw_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
        end
    end

    // Table survives reset; the combinational read above sees pre-write data.
    always_ff @(posedge CLOCK_50) begin
        if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    assign SW          = sw_q;
    assign KEY         = key_q;
    assign step_strobe = strobe_q;
    assign step_count  = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_io_stim_sequencer.sv
// Bench for io_stim_sequencer: directed vector table, multi-cycle corner sequences
// and randomized traffic compared cycle by cycle against a step-counting model.
module tb_io_stim_sequencer;

    localparam int unsigned SWB = 10;
    localparam int unsigned KB  = 4;
    localparam int unsigned PER = 4;
    localparam int unsigned SD  = 2;
    localparam int unsigned DEP = 8;
    localparam int unsigned AW  = 3;
    localparam int unsigned TW  = SWB + KB;

    logic            CLOCK_50;
    logic            RESET;
    logic            enable;
    logic [1:0]      mode;
    logic            loop;
    logic            tbl_we;
    logic [AW-1:0]   tbl_addr;
    logic [TW-1:0]   tbl_data;
    logic [SWB-1:0]  SW;
    logic [KB-1:0]   KEY;
    logic            step_strobe;
    logic [15:0]     step_count;
    logic            done;

    io_stim_sequencer #(
        .SW_BITS     (SWB),
        .KEY_BITS    (KB),
        .PERIOD      (PER),
        .START_DELAY (SD),
        .DEPTH       (DEP)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .enable      (enable),
        .mode        (mode),
        .loop        (loop),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .SW          (SW),
        .KEY         (KEY),
        .step_strobe (step_strobe),
        .step_count  (step_count),
        .done        (done)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: a step happens on every PER-th enabled cycle after hold-off.
    logic [SWB-1:0] m_sw;
    logic [KB-1:0]  m_key;
    bit             m_strobe;
    bit             m_done;
    int             m_count;
    int             m_idx;
    int             m_since;
    int             m_run;
    logic [TW-1:0]  m_tbl [DEP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [TW-1:0] rd;
        int            v;
        int            k;
        bit            step;
        step = 1'b0;
        if (RESET) begin
            m_sw = '1; m_key = '1; m_strobe = 1'b0; m_done = 1'b0;
            m_count = 0; m_idx = 0; m_since = 0; m_run = 0;
        end else begin
            m_strobe = 1'b0;
            if (m_since < ((SD > 0) ? int'(SD) : 1)) begin
                m_since++;
            end else if (!m_done && enable) begin
                m_run++;
                step = ((m_run % PER) == 0);
            end
            if (step) begin
                m_strobe = 1'b1;
                if (m_count < 65535) m_count++;
                case (mode)
                    2'd0: begin
                        m_sw  = ~m_sw;
                        m_key = ~m_key;
                    end
                    2'd1: begin
                        v = int'(m_sw);
                        k = int'(m_key);
                        m_sw  = SWB'(((v * 2) % (1 << SWB)) + (v / (1 << (SWB - 1))));
                        m_key = KB'(((k * 2) % (1 << KB)) + (k / (1 << (KB - 1))));
                    end
                    2'd2: begin
                        rd    = m_tbl[m_idx];
                        m_sw  = SWB'(rd / (1 << KB));
                        m_key = KB'(rd % (1 << KB));
                        if (m_idx == DEP - 1 && !loop) m_done = 1'b1;
                        m_idx = (m_idx + 1) % DEP;
                    end
                    default: ;
                endcase
            end
        end
        if (tbl_we) m_tbl[tbl_addr] = tbl_data;
    endtask

    // One clock: advance the model with the current inputs, then compare everything.
    task automatic cycle();
        model_update();
        @(posedge CLOCK_50);
        #1;
        chk("model_sw", 32'(SW), 32'(m_sw));
        chk("model_key", 32'(KEY), 32'(m_key));
        chk("model_strobe", 32'(step_strobe), 32'(m_strobe));
        chk("model_count", 32'(step_count), 32'(m_count));
        chk("model_done", 32'(done), 32'(m_done));
    endtask

    task automatic wait_strobe(input int max_cycles, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < max_cycles) begin
            cycle();
            n++;
            if (step_strobe) got = 1'b1;
        end
        chk("strobe_within_bound", 32'(got), 32'd1);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        tbl_we = 1'b0;
        cycle();
        RESET = 1'b0;
    endtask

    typedef struct {
        bit             rst;
        bit             en;
        logic [1:0]     md;
        logic [SWB-1:0] exp_sw;
        logic [KB-1:0]  exp_key;
        bit             exp_stb;
        int             exp_cnt;
    } vec_t;

    vec_t           vecs [11];
    logic [TW-1:0]  init_tbl [DEP];

    initial begin
        int n;
        int strobes;
        logic [SWB-1:0] e_sw;
        logic [KB-1:0]  e_key;

        RESET = 1'b1; enable = 1'b1; mode = 2'd0; loop = 1'b1;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;

        // Load the whole table while held in reset.
        for (int i = 0; i < DEP; i++) begin
            init_tbl[i] = {SWB'(12'h0A0 + i * 3), KB'(i + 1)};
            tbl_we   = 1'b1;
            tbl_addr = AW'(i);
            tbl_data = init_tbl[i];
            cycle();
        end
        tbl_we = 1'b0;

        // Toggle from reset: first step 6 cycles after release, second at cycle 10.
        for (int i = 0; i < 11; i++) begin
            vecs[i] = '{rst: (i == 0), en: 1'b1, md: 2'd0, exp_sw: 10'h3FF,
                        exp_key: 4'hF, exp_stb: 1'b0, exp_cnt: 0};
        end
        for (int i = 6; i < 10; i++) begin
            vecs[i].exp_sw = 10'h000; vecs[i].exp_key = 4'h0; vecs[i].exp_cnt = 1;
        end
        vecs[6].exp_stb = 1'b1;
        vecs[10].exp_stb = 1'b1;
        vecs[10].exp_cnt = 2;
        for (int i = 0; i < 11; i++) begin
            RESET = vecs[i].rst; enable = vecs[i].en; mode = vecs[i].md;
            cycle();
            chk($sformatf("vec%0d_sw", i), 32'(SW), 32'(vecs[i].exp_sw));
            chk($sformatf("vec%0d_key", i), 32'(KEY), 32'(vecs[i].exp_key));
            chk($sformatf("vec%0d_strobe", i), 32'(step_strobe), 32'(vecs[i].exp_stb));
            chk($sformatf("vec%0d_count", i), 32'(step_count), 32'(vecs[i].exp_cnt));
        end

        // Table playback without loop: eight steps then DONE, outputs frozen.
        pulse_reset();
        mode = 2'd2; loop = 1'b0; enable = 1'b1;
        strobes = 0;
        for (int c = 0; c < DEP * PER + SD + 12; c++) begin
            cycle();
            if (step_strobe) begin
                chk($sformatf("tbl_step%0d_sw", strobes), 32'(SW), 32'(init_tbl[strobes] >> KB));
                chk($sformatf("tbl_step%0d_done", strobes), 32'(done),
                    32'(strobes == DEP - 1));
                strobes++;
            end
        end
        chk("tbl_strobes", 32'(strobes), 32'(DEP));
        chk("tbl_done", 32'(done), 32'd1);
        chk("tbl_final_sw", 32'(SW), 32'(init_tbl[DEP-1] >> KB));
        chk("tbl_final_key", 32'(KEY), 32'(init_tbl[DEP-1] % 16));

        // Walk: preload 001 via one table step, then rotate through the wrap.
        RESET = 1'b1;
        tbl_we = 1'b1; tbl_addr = '0; tbl_data = {10'h001, 4'h1};
        cycle();
        RESET = 1'b0; tbl_we = 1'b0;
        mode = 2'd2; loop = 1'b1; enable = 1'b1;
        wait_strobe(20, n);
        chk("walk_preload_sw", 32'(SW), 32'h001);
        mode = 2'd1;
        for (int k = 1; k <= 10; k++) begin
            wait_strobe(PER + 2, n);
            e_sw  = SWB'(1 << (k % 10));
            e_key = KB'(1 << (k % 4));
            chk($sformatf("walk%0d_sw", k), 32'(SW), 32'(e_sw));
            chk($sformatf("walk%0d_key", k), 32'(KEY), 32'(e_key));
        end

        // Pause of 5 cycles with the period counter at 2 delays the step by 5.
        pulse_reset();
        mode = 2'd0; enable = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        enable = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        enable = 1'b1;
        wait_strobe(20, n);
        chk("pause_step_cycle", 32'(9 + n), 32'(SD + PER + 5));

        // Reset one cycle with the counter at PERIOD-1 in table mode.
        pulse_reset();
        mode = 2'd2; loop = 1'b1; enable = 1'b1;
        for (int c = 0; c < 9; c++) cycle();
        chk("midrst_pre_sw", 32'(SW), 32'h001);
        RESET = 1'b1;
        cycle();
        chk("midrst_sw", 32'(SW), 32'h3FF);
        chk("midrst_key", 32'(KEY), 32'hF);
        chk("midrst_count", 32'(step_count), 32'd0);
        RESET = 1'b0;
        wait_strobe(20, n);
        chk("midrst_table_kept", 32'(SW), 32'h001);

        // Write to entry 0 on the step that reads it: old data now, new on wrap.
        pulse_reset();
        mode = 2'd2; loop = 1'b1; enable = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        tbl_we = 1'b1; tbl_addr = '0; tbl_data = {10'h2AA, 4'h5};
        cycle();
        tbl_we = 1'b0;
        chk("rbw_strobe", 32'(step_strobe), 32'd1);
        chk("rbw_old_sw", 32'(SW), 32'h001);
        chk("rbw_old_key", 32'(KEY), 32'h1);
        for (int k = 1; k <= DEP; k++) wait_strobe(PER + 2, n);
        chk("rbw_new_sw", 32'(SW), 32'h2AA);
        chk("rbw_new_key", 32'(KEY), 32'h5);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            RESET    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            loop     = ($urandom_range(0, 3) != 0);
            tbl_we   = ($urandom_range(0, 9) == 0);
            tbl_addr = AW'($urandom);
            tbl_data = TW'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
